// File: rtl/pio_pkg.sv
// ============================================================================
// Module : pio_pkg
// Brief  : Register map for the debounced edge-capture input PIO.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pio_pkg;

    // Word addresses on the s1 slave; access type noted per register.
    localparam logic [2:0] PIO_DATA         = 3'd0; // RO  debounced value
    localparam logic [2:0] PIO_RAW          = 3'd1; // RO  synchronised value
    localparam logic [2:0] PIO_IRQ_MASK     = 3'd2; // RW
    localparam logic [2:0] PIO_EDGE_CAPTURE = 3'd3; // W1C
    localparam logic [2:0] PIO_RISE_EN      = 3'd4; // RW
    localparam logic [2:0] PIO_FALL_EN      = 3'd5; // RW
    localparam logic [2:0] PIO_DEB_PERIOD   = 3'd6; // RW  [CNT_W-1:0]
    localparam logic [2:0] PIO_RESERVED     = 3'd7; // reads 0, writes ignored

endpackage

`default_nettype wire

// File: rtl/pio_debounce_ch.sv
// ============================================================================
// Module : pio_debounce_ch
// Brief  : One input channel: synchroniser chain, debounce counter, change pulse.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pio_debounce_ch #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_async,
    input  logic [CNT_W-1:0] i_period,
    output logic             o_sync,
    output logic             o_deb,
    output logic             o_change,
    output logic             o_deb_new
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_deb;
    logic                   w_sync;
    logic [CNT_W:0]         w_cnt_inc;
    logic                   w_commit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
        end
    end

    assign w_sync    = r_sync[SYNC_STAGES-1];
    // One extra bit so the compare is exact even at the top of the counter range.
    assign w_cnt_inc = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign w_commit  = (w_sync != r_deb) && (w_cnt_inc >= {1'b0, i_period});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_deb <= 1'b0;
        end else if (w_sync == r_deb) begin
            r_cnt <= '0;
        end else if (w_commit) begin
            r_deb <= w_sync;
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_inc[CNT_W-1:0];
        end
    end

    assign o_sync    = w_sync;
    assign o_deb     = r_deb;
    assign o_change  = w_commit;
    assign o_deb_new = w_sync;

endmodule

`default_nettype wire

// File: rtl/pio_in_debounce_irq.sv
// ============================================================================
// Module : pio_in_debounce_irq
// Brief  : Avalon-MM input PIO with debounce, edge select, W1C capture and irq.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pio_in_debounce_irq
    import pio_pkg::*;
#(
    parameter int WIDTH       = 10,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    parameter int DEB_RESET   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_cap;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic [CNT_W-1:0] r_period;
    logic [31:0]      r_readdata;

    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_deb;
    logic [WIDTH-1:0] w_change;
    logic [WIDTH-1:0] w_deb_new;
    logic [WIDTH-1:0] w_event;
    logic [WIDTH-1:0] w_clr;
    logic [31:0]      w_rd_next;
    logic             w_wr;
    logic             w_unused;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_ch
            pio_debounce_ch #(
                .SYNC_STAGES (SYNC_STAGES),
                .CNT_W       (CNT_W)
            ) u_ch (
                .clk       (clk),
                .reset_n   (reset_n),
                .i_async   (in_port[gi]),
                .i_period  (r_period),
                .o_sync    (w_sync[gi]),
                .o_deb     (w_deb[gi]),
                .o_change  (w_change[gi]),
                .o_deb_new (w_deb_new[gi])
            );
        end
    endgenerate

    assign w_wr    = chipselect & ~write_n;
    assign w_event = w_change & ((w_deb_new & r_rise) | (~w_deb_new & r_fall));
    assign w_clr   = (w_wr && address == PIO_EDGE_CAPTURE) ? writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask   <= '0;
            r_cap    <= '0;
            r_rise   <= '1;
            r_fall   <= '0;
            r_period <= CNT_W'(DEB_RESET);
        end else begin
            // OR-ing the event after the clear keeps an edge that lands with its own W1C.
            r_cap <= (r_cap & ~w_clr) | w_event;
            if (w_wr) begin
                case (address)
                    PIO_IRQ_MASK:   r_mask   <= writedata[WIDTH-1:0];
                    PIO_RISE_EN:    r_rise   <= writedata[WIDTH-1:0];
                    PIO_FALL_EN:    r_fall   <= writedata[WIDTH-1:0];
                    PIO_DEB_PERIOD: r_period <= writedata[CNT_W-1:0];
                    default:        ;
                endcase
            end
        end
    end

    always_comb begin
        w_rd_next = '0;
        case (address)
            PIO_DATA:         w_rd_next[WIDTH-1:0] = w_deb;
            PIO_RAW:          w_rd_next[WIDTH-1:0] = w_sync;
            PIO_IRQ_MASK:     w_rd_next[WIDTH-1:0] = r_mask;
            PIO_EDGE_CAPTURE: w_rd_next[WIDTH-1:0] = r_cap;
            PIO_RISE_EN:      w_rd_next[WIDTH-1:0] = r_rise;
            PIO_FALL_EN:      w_rd_next[WIDTH-1:0] = r_fall;
            PIO_DEB_PERIOD:   w_rd_next[CNT_W-1:0] = r_period;
            default:          w_rd_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rd_next;
        end
    end

    assign readdata = r_readdata;
    assign irq      = |(r_cap & r_mask);
    assign w_unused = ^writedata;

endmodule

`default_nettype wire

// File: tb/tb_pio_in_debounce_irq.sv
// ============================================================================
// Module : tb_pio_in_debounce_irq
// Brief  : Directed + random bench against a cycle-level behavioural model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pio_in_debounce_irq;

    localparam int W  = 10;
    localparam int S  = 2;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [2:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [W-1:0]  in_port;
    logic [31:0]   readdata;
    logic          irq;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [W-1:0]  m_sh [S];
    logic [W-1:0]  m_deb, m_mask, m_cap, m_rise, m_fall;
    logic [CW-1:0] m_per;
    int            m_run [W];
    logic [31:0]   m_rd;

    pio_in_debounce_irq #(
        .WIDTH       (W),
        .SYNC_STAGES (S),
        .CNT_W       (CW),
        .DEB_RESET   (0)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    function automatic void m_reset();
        for (int k = 0; k < S; k++) m_sh[k] = '0;
        for (int i = 0; i < W; i++) m_run[i] = 0;
        m_deb  = '0;
        m_mask = '0;
        m_cap  = '0;
        m_rise = '1;
        m_fall = '0;
        m_per  = '0;
        m_rd   = '0;
    endfunction

    // A channel's debounced value follows the synchronised input once the two
    // have disagreed for max(period,1) consecutive cycles.
    function automatic void m_step();
        logic [W-1:0] s, dn, ev, clr;
        int p;
        s = m_sh[S-1];
        case (address)
            3'd0:    m_rd = 32'(m_deb);
            3'd1:    m_rd = 32'(s);
            3'd2:    m_rd = 32'(m_mask);
            3'd3:    m_rd = 32'(m_cap);
            3'd4:    m_rd = 32'(m_rise);
            3'd5:    m_rd = 32'(m_fall);
            3'd6:    m_rd = 32'(m_per);
            default: m_rd = 32'd0;
        endcase
        p  = (m_per == 0) ? 1 : int'(m_per);
        dn = m_deb;
        ev = '0;
        for (int i = 0; i < W; i++) begin
            if (s[i] != m_deb[i]) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] >= p) begin
                    dn[i]    = s[i];
                    m_run[i] = 0;
                    ev[i]    = s[i] ? m_rise[i] : m_fall[i];
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_deb = dn;
        clr   = (chipselect && !write_n && address == 3'd3) ? writedata[W-1:0] : '0;
        m_cap = (m_cap & ~clr) | ev;
        if (chipselect && !write_n) begin
            case (address)
                3'd2:    m_mask = writedata[W-1:0];
                3'd4:    m_rise = writedata[W-1:0];
                3'd5:    m_fall = writedata[W-1:0];
                3'd6:    m_per  = writedata[CW-1:0];
                default: ;
            endcase
        end
        for (int k = S-1; k > 0; k--) m_sh[k] = m_sh[k-1];
        m_sh[0] = in_port;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        m_step();
        @(negedge clk);
        chk("readdata", readdata, m_rd);
        chk("irq", {31'd0, irq}, {31'd0, |(m_cap & m_mask)});
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
        cyc();
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 10'h3FF;
        m_reset();

        // Reset with all inputs high, bypass debounce
        repeat (3) @(negedge clk);
        chk("reset_rd", readdata, 32'd0);
        chk("reset_irq", {31'd0, irq}, 32'd0);
        reset_n = 1'b1;
        repeat (3) cyc();
        cyc();
        chk("t1_data", readdata, 32'h3FF);
        address = 3'd3;
        cyc();
        chk("t1_cap", readdata, 32'h3FF);
        chk("t1_irq", {31'd0, irq}, 32'd0);
        address = 3'd4;
        cyc();
        chk("t1_rise_rst", readdata, 32'h3FF);

        // Debounce: short glitch rejected, long level accepted at S+5
        in_port = '0;
        wr(3'd6, 32'd5);
        repeat (12) cyc();
        wr(3'd3, 32'h3FF);
        address = 3'd0;
        in_port[0] = 1'b1;
        repeat (4) cyc();
        in_port[0] = 1'b0;
        repeat (10) cyc();
        chk("t2_glitch", {31'd0, readdata[0]}, 32'd0);
        in_port[0] = 1'b1;
        repeat (S + 5) cyc();
        chk("t2_before", {31'd0, readdata[0]}, 32'd0);
        cyc();
        chk("t2_after", {31'd0, readdata[0]}, 32'd1);

        // Edge select: falling only on bit 3
        wr(3'd4, 32'h3F7);
        wr(3'd5, 32'h008);
        wr(3'd3, 32'h3FF);
        in_port[3] = 1'b1;
        repeat (12) cyc();
        address = 3'd3;
        cyc();
        chk("t3_rise", {31'd0, readdata[3]}, 32'd0);
        in_port[3] = 1'b0;
        repeat (12) cyc();
        chk("t3_fall", {31'd0, readdata[3]}, 32'd1);

        // W1C
        wr(3'd4, 32'h3FF);
        wr(3'd5, 32'h000);
        in_port = '0;
        repeat (12) cyc();
        wr(3'd3, 32'h3FF);
        in_port = 10'h011;
        repeat (12) cyc();
        address = 3'd3;
        cyc();
        chk("t4_cap", readdata, 32'h011);
        wr(3'd3, 32'h001);
        cyc();
        chk("t4_w1c", readdata, 32'h010);
        wr(3'd3, 32'h000);
        cyc();
        chk("t4_w0", readdata, 32'h010);

        // Collision: falling edge on bit 2 lands with its own W1C
        wr(3'd2, 32'h004);
        wr(3'd6, 32'h0);
        wr(3'd5, 32'h004);
        in_port[2] = 1'b1;
        repeat (4) cyc();
        chk("t5_irq_pre", {31'd0, irq}, 32'd1);
        in_port[2] = 1'b0;
        cyc();
        cyc();
        wr(3'd3, 32'h004);
        address = 3'd3;
        cyc();
        chk("t5_cap", {31'd0, readdata[2]}, 32'd1);
        chk("t5_irq", {31'd0, irq}, 32'd1);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            int op;
            op = int'($urandom_range(0, 9));
            if (op < 3) begin
                in_port = in_port ^ W'($urandom);
                cyc();
            end else if (op < 6) begin
                logic [2:0] a;
                a = 3'($urandom);
                if (a == 3'd6)
                    wr(a, {16'($urandom), 16'($urandom_range(0, 8))});
                else
                    wr(a, $urandom);
            end else begin
                address = 3'($urandom);
                cyc();
            end
        end

        // Period shrink mid-count
        wr(3'd6, 32'd100);
        wr(3'd3, 32'h3FF);
        address = 3'd0;
        in_port = '0;
        repeat (110) cyc();
        in_port[1] = 1'b1;
        repeat (50) cyc();
        chk("t6_hold", {31'd0, readdata[1]}, 32'd0);
        wr(3'd6, 32'd10);
        address = 3'd0;
        cyc();
        cyc();
        chk("t6_commit", {31'd0, readdata[1]}, 32'd1);

        // Async reset mid-count with irq asserted
        wr(3'd6, 32'd0);
        wr(3'd2, 32'h3FF);
        in_port = ~in_port;
        repeat (5) cyc();
        chk("t6_irq_pre", {31'd0, irq}, 32'd1);
        wr(3'd6, 32'd100);
        in_port = ~in_port;
        repeat (20) cyc();
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_irq", {31'd0, irq}, 32'd0);
        chk("t6_rst_rd", readdata, 32'd0);
        m_reset();
        @(negedge clk);
        reset_n = 1'b1;
        for (int a = 0; a < 8; a++) begin
            address = 3'(a);
            cyc();
        end
        repeat (8) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
